// File: rtl/xbus_responder.sv
// -----------------------------------------------------------------------------
// xbus_responder
//
// Bridges a 4-phase word bus to a host-side FIFO interface.
//   RX path: the bus controller writes words into a 4-entry RX FIFO, and the
//            host pops them.
//   TX path: the host pushes words into a 4-entry TX FIFO, and the bus
//            controller reads them out.
//
// Ports
//   clk, reset                  rising-edge clock, asynchronous active-high reset
//   bus_dat_in[10:0]            word written by the controller
//   bus_write_in                controller offers bus_dat_in
//   bus_read_out                responder has captured bus_dat_in (ack)
//   bus_read_in                 controller requests a word
//   bus_dat_out[10:0]           word offered to the controller (0 when idle)
//   bus_write_out               responder offers bus_dat_out
//   host_push_dat[10:0]         word to push into TX
//   host_push_en                push strobe (ignored when host_full)
//   host_full                   TX FIFO full
//   host_pop_en                 pop strobe (ignored when host_empty)
//   host_pop_dat[10:0]          RX FIFO head, combinational (0 when empty)
//   host_empty                  RX FIFO empty
//   drop_cnt[7:0]               saturating count of pushes rejected while full
//
// Build option
//   XBUS_DROP_CNT_EN  -- when defined, drop_cnt counts cycles with
//                        host_push_en=1 while TX is full (saturates at 255).
//                        When undefined, drop_cnt is tied to 0.
// -----------------------------------------------------------------------------
module xbus_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] bus_dat_in,
  input  logic        bus_write_in,
  input  logic        bus_read_in,
  output logic [10:0] bus_dat_out,
  output logic        bus_write_out,
  output logic        bus_read_out,
  input  logic [10:0] host_push_dat,
  input  logic        host_push_en,
  input  logic        host_pop_en,
  output logic [10:0] host_pop_dat,
  output logic        host_full,
  output logic        host_empty,
  output logic [7:0]  drop_cnt
);

  typedef enum logic {RX_IDLE = 1'b0, RX_ACK   = 1'b1} rx_state_t;
  typedef enum logic {TX_IDLE = 1'b0, TX_OFFER = 1'b1} tx_state_t;

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [10:0] r_rx_mem [4];
  logic [1:0]  r_rx_wptr, r_rx_rptr;
  logic [2:0]  r_rx_cnt;

  logic [10:0] r_tx_mem [4];
  logic [1:0]  r_tx_wptr, r_tx_rptr;
  logic [2:0]  r_tx_cnt;

  rx_state_t   r_rx_state, w_rx_state_nxt;
  tx_state_t   r_tx_state, w_tx_state_nxt;
  logic [10:0] r_bus_dat_out, w_bus_dat_nxt;

  logic w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
  logic w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;

  assign w_rx_full  = (r_rx_cnt == 3'd4);
  assign w_rx_empty = (r_rx_cnt == 3'd0);
  assign w_tx_full  = (r_tx_cnt == 3'd4);
  assign w_tx_empty = (r_tx_cnt == 3'd0);

  // Host-side strobes are qualified by the flags as seen before the edge, so a
  // push into a full TX is rejected even if the bus pops in the same cycle.
  assign w_tx_push = host_push_en & ~w_tx_full;
  assign w_rx_pop  = host_pop_en  & ~w_rx_empty;

  // ---------------------------------------------------------------------------
  // RX handshake FSM: capture once per bus_write_in assertion
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) r_rx_state <= RX_IDLE;
    else       r_rx_state <= w_rx_state_nxt;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    w_rx_state_nxt = r_rx_state;
    w_rx_push      = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        // A full RX leaves the controller stalled with no ack.
        if (bus_write_in && !w_rx_full) begin
          w_rx_push      = 1'b1;
          w_rx_state_nxt = RX_ACK;
        end
      end
      RX_ACK: begin
        if (!bus_write_in) w_rx_state_nxt = RX_IDLE;
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  assign bus_read_out = (r_rx_state == RX_ACK);

  // ---------------------------------------------------------------------------
  // TX handshake FSM: offer head, pop when the controller releases
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state    <= TX_IDLE;
      r_bus_dat_out <= 11'd0;
    end else begin
      r_tx_state    <= w_tx_state_nxt;
      r_bus_dat_out <= w_bus_dat_nxt;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_bus_dat_nxt  = r_bus_dat_out;
    w_tx_pop       = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (bus_read_in && !w_tx_empty) begin
          w_bus_dat_nxt  = r_tx_mem[r_tx_rptr];
          w_tx_state_nxt = TX_OFFER;
        end
      end
      TX_OFFER: begin
        // The word leaves the FIFO only once the controller has let go.
        if (!bus_read_in) begin
          w_tx_pop       = 1'b1;
          w_bus_dat_nxt  = 11'd0;
          w_tx_state_nxt = TX_IDLE;
        end
      end
      default: begin
        w_bus_dat_nxt  = 11'd0;
        w_tx_state_nxt = TX_IDLE;
      end
    endcase
  end

  assign bus_write_out = (r_tx_state == TX_OFFER);
  assign bus_dat_out   = r_bus_dat_out;

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  // NOTE: the data arrays carry no reset; only pointers and counts do, and
  // stale entries are never visible because reads are gated by the counts.
  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= bus_dat_in;
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= host_push_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_wptr <= 2'd0;
      r_rx_rptr <= 2'd0;
      r_rx_cnt  <= 3'd0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + 2'd1;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 2'd1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + 3'd1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 3'd1;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_wptr <= 2'd0;
      r_tx_rptr <= 2'd0;
      r_tx_cnt  <= 3'd0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + 2'd1;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 2'd1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + 3'd1;
        2'b01:   r_tx_cnt <= r_tx_cnt - 3'd1;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  assign host_full    = w_tx_full;
  assign host_empty   = w_rx_empty;
  assign host_pop_dat = w_rx_empty ? 11'd0 : r_rx_mem[r_rx_rptr];

  // ---------------------------------------------------------------------------
  // Rejected-push counter
  // ---------------------------------------------------------------------------
`ifdef XBUS_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_drop_cnt <= 8'd0;
    else if (host_push_en && w_tx_full && (r_drop_cnt != 8'hff))
      r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 8'd0;
`endif

endmodule
